// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state type and counter width shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int CNT_W = $clog2(5);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    return write ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                 : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/lane-replication for stores, shift/extend for loads, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [31:0] sh;
  always_comb begin
    sh         = rdata >> {addr_lo, 3'b000};
    be         = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                 funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep  = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    misaligned = funct3[1:0] == 2'b01 ? addr_lo[0] :
                 funct3[1:0] == 2'b10 ? |addr_lo : 1'b0;
    rdata_ext  = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                 funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3 == F3_BU ? {24'b0, sh[7:0]} :
                 funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store per handshake, IDLE -> ACCESS -> RESP, faults skip ACCESS.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_wren,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d, fault_q, fault_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic             idle, in_acc, misaligned;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, rdata_ext;
  assign idle   = state_q == IDLE;
  assign in_acc = state_q == ACCESS;
  // In IDLE the aligner checks the incoming request; afterwards it works on the registered one.
  lsu_align u_align (
    .funct3    (idle ? req_funct3 : f3_q),
    .addr_lo   (idle ? req_addr[1:0] : addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misaligned(misaligned)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    fault_d = fault_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        write_d = req_write;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        cnt_d   = '0;
        fault_d = !f3_legal(req_write, req_funct3) || misaligned;
        state_d = fault_d ? RESP : ACCESS;
      end
      ACCESS: if (write_q) state_d = RESP;
      else if (cnt_q == CNT_W'(MEM_RD_LATENCY)) begin
        rdata_d = rdata_ext;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      fault_q <= fault_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_ready  = reset_n && idle;
  assign resp_valid = state_q == RESP;
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = in_acc ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wren   = in_acc && write_q;
  assign mem_be     = in_acc ? be : '0;
  assign mem_wdata  = in_acc ? wdata_rep : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven vectors with a response scoreboard, plus reset/back-to-back/latency sequences.
module tb_load_store_unit;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_valid3 = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, rdword = '0;
  logic        req_ready, resp_valid, resp_fault, mem_wren;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        req_ready3, resp_valid3, resp_fault3, mem_wren3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;
  int tests = 0, fails = 0, cnt1 = 0, cnt3 = 0;
  always #5 clk = ~clk;
  load_store_unit #(.MEM_RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));
  load_store_unit #(.MEM_RD_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_fault(resp_fault3),
    .mem_addr(mem_addr3), .mem_wren(mem_wren3), .mem_be(mem_be3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3));
  // Memory models: read data is only valid once the address has been held for the latency.
  always @(posedge clk) begin
    cnt1 <= (mem_addr != 0 && !mem_wren) ? cnt1 + 1 : 0;
    cnt3 <= (mem_addr3 != 0 && !mem_wren3) ? cnt3 + 1 : 0;
  end
  assign mem_rdata  = cnt1 >= 1 ? rdword : 32'h5A5A5A5A;
  assign mem_rdata3 = cnt3 >= 3 ? rdword : 32'h5A5A5A5A;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, word;
    logic [3:0]  be;
    logic [31:0] wrep, rdata;
    logic        fault;
    int          due;
  } vec_t;
  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  vec_t vecs[15];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    bit got = 0, strobe = 0;
    wait_ready();
    rdword = v.word;
    req_write = v.write; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    sb.push_back('{v.fault, v.rdata, v.due});
    for (int n = 1; n <= 10 && !got; n++) begin
      @(negedge clk);
      strobe |= mem_wren || mem_be != 0;
      if (n == 1 && !v.fault) begin
        check($sformatf("v%0d_addr", idx), mem_addr, v.addr & ~32'h3);
        check($sformatf("v%0d_wren", idx), mem_wren, v.write);
        if (v.write) begin
          check($sformatf("v%0d_be", idx), mem_be, v.be);
          check($sformatf("v%0d_wdata", idx), mem_wdata, v.wrep);
        end
      end
      if (resp_valid) begin
        got = 1;
        e = sb.pop_front();
        check($sformatf("v%0d_cycle", idx), n, e.due);
        check($sformatf("v%0d_fault", idx), resp_fault, e.fault);
        check($sformatf("v%0d_rdata", idx), resp_rdata, e.rdata);
      end
    end
    if (!got) begin
      check($sformatf("v%0d_resp_timeout", idx), 0, 1);
      sb.delete();
    end
    if (v.fault) check($sformatf("v%0d_no_strobe", idx), strobe, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 3'b010, 32'h2004, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 0, 0, 2};
    vecs[1]  = '{1, 3'b000, 32'h2003, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5, 0, 0, 2};
    vecs[2]  = '{1, 3'b001, 32'h2002, 32'h00001234, 0, 4'b1100, 32'h12341234, 0, 0, 2};
    vecs[3]  = '{1, 3'b000, 32'h2000, 32'h12345678, 0, 4'b0001, 32'h78787878, 0, 0, 2};
    vecs[4]  = '{1, 3'b001, 32'h2000, 32'hABCD5678, 0, 4'b0011, 32'h56785678, 0, 0, 2};
    vecs[5]  = '{0, 3'b000, 32'h2001, 0, 32'h80FF7F01, 0, 0, 32'h0000007F, 0, 3};
    vecs[6]  = '{0, 3'b000, 32'h2002, 0, 32'h80FF7F01, 0, 0, 32'hFFFFFFFF, 0, 3};
    vecs[7]  = '{0, 3'b100, 32'h2003, 0, 32'h80FF7F01, 0, 0, 32'h00000080, 0, 3};
    vecs[8]  = '{0, 3'b001, 32'h2002, 0, 32'h80FF7F01, 0, 0, 32'hFFFF80FF, 0, 3};
    vecs[9]  = '{0, 3'b101, 32'h2002, 0, 32'h80FF7F01, 0, 0, 32'h000080FF, 0, 3};
    vecs[10] = '{0, 3'b010, 32'h2000, 0, 32'h80FF7F01, 0, 0, 32'h80FF7F01, 0, 3};
    vecs[11] = '{0, 3'b010, 32'h2002, 0, 32'h80FF7F01, 0, 0, 0, 1, 1};
    vecs[12] = '{1, 3'b001, 32'h2001, 32'h1234, 0, 0, 0, 0, 1, 1};
    vecs[13] = '{1, 3'b100, 32'h2000, 32'h1234, 0, 0, 0, 0, 1, 1};
    vecs[14] = '{0, 3'b011, 32'h2000, 0, 32'h80FF7F01, 0, 0, 0, 1, 1};
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk) reset_n = 1'b1;
    #1 check("post_rst_ready", req_ready, 1);
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted while a store is in ACCESS abandons it.
    wait_ready();
    req_write = 1; req_funct3 = 3'b010; req_addr = 32'h2008; req_wdata = 32'hCAFEF00D; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("rst_mid_wren_before", mem_wren, 1);
    #1 reset_n = 0;
    #1 check("rst_mid_wren", mem_wren, 0);
    check("rst_mid_be", mem_be, 0);
    check("rst_mid_ready", req_ready, 0);
    @(negedge clk) reset_n = 1;
    #1 check("rst_rel_ready", req_ready, 1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("rst_no_resp%0d", n), resp_valid, 0);
    end

    // Back-to-back with req_valid held high.
    wait_ready();
    req_write = 1; req_funct3 = 3'b010; req_addr = 32'h3000; req_wdata = 32'h11111111; req_valid = 1;
    @(posedge clk);
    #1 begin req_funct3 = 3'b000; req_addr = 32'h3001; req_wdata = 32'h22; end
    @(negedge clk) check("b2b_c1_ready", req_ready, 0);
    @(negedge clk) check("b2b_c2_resp", resp_valid, 1);
    @(negedge clk) check("b2b_c3_ready", req_ready, 1);
    check("b2b_c3_resp", resp_valid, 0);
    @(negedge clk);
    req_valid = 0;
    check("b2b_c4_wren", mem_wren, 1);
    check("b2b_c4_be", mem_be, 4'b0010);
    check("b2b_c4_wdata", mem_wdata, 32'h22222222);
    @(negedge clk) check("b2b_c5_resp", resp_valid, 1);

    // MEM_RD_LATENCY=3 instance: load response in cycle 5.
    begin
      bit got = 0;
      @(negedge clk);
      rdword = 32'h80FF7F01;
      req_write = 0; req_funct3 = 3'b000; req_addr = 32'h2002; req_valid3 = 1;
      @(posedge clk);
      #1 req_valid3 = 0;
      for (int n = 1; n <= 10 && !got; n++) begin
        @(negedge clk);
        if (resp_valid3) begin
          got = 1;
          check("lat3_cycle", n, 5);
          check("lat3_rdata", resp_rdata3, 32'hFFFFFFFF);
          check("lat3_fault", resp_fault3, 0);
        end
      end
      if (!got) check("lat3_timeout", 0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
